// File: rtl/layer_requant_buffer.sv
// layer_requant_buffer: collects eight 16-bit neuron results, requantizes each to
// signed 8-bit and presents them as a parallel 8-lane vector with a valid/ready
// handshake.
// Optional feature macro LRB_ROUND_EN: when defined the requantizer rounds
// half-up, otherwise it floors (truncates toward -inf).
module layer_requant_buffer #(
   parameter int unsigned SHIFT = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_x0,
   output logic [7:0]  out_x1,
   output logic [7:0]  out_x2,
   output logic [7:0]  out_x3,
   output logic [7:0]  out_x4,
   output logic [7:0]  out_x5,
   output logic [7:0]  out_x6,
   output logic [7:0]  out_x7,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  fill_count,
   output logic        overrun
);

   typedef enum logic {StFill, StFull} state_e;

`ifdef LRB_ROUND_EN
   localparam int RoundInt = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
`else
   localparam int RoundInt = 0;
`endif
   localparam logic signed [17:0] RoundTerm = 18'(RoundInt);

   state_e             r_state;
   state_e             w_state_next;
   logic [3:0]         r_fill_count;
   logic [3:0]         w_fill_count_next;
   logic [7:0]         r_lane [8];
   logic               r_overrun;
   logic               w_accept;
   logic signed [17:0] w_ext;
   logic signed [17:0] w_sum;
   logic signed [17:0] w_shifted;
   logic [7:0]         w_q8;

   // 18-bit signed requantizer: add rounding term, arithmetic shift, saturate.
   always_comb begin
      w_ext     = {{2{in_data[15]}}, in_data};
      w_sum     = w_ext + RoundTerm;
      w_shifted = w_sum >>> SHIFT;
      if (w_shifted > 18'sd127) begin
         w_q8 = 8'h7F;
      end else if (w_shifted < -18'sd128) begin
         w_q8 = 8'h80;
      end else begin
         w_q8 = w_shifted[7:0];
      end
   end

   assign w_accept = (r_state == StFill) && in_valid;

   // Next-state logic: fill eight beats, then hold until the consumer releases.
   always_comb begin
      w_state_next      = r_state;
      w_fill_count_next = r_fill_count;
      unique case (r_state)
         StFill: begin
            if (in_valid) begin
               w_fill_count_next = r_fill_count + 4'd1;
               if (r_fill_count == 4'd7) begin
                  w_state_next = StFull;
               end
            end
         end
         StFull: begin
            if (out_ready) begin
               w_fill_count_next = 4'd0;
               w_state_next      = StFill;
            end
         end
         default: begin
            w_state_next      = StFill;
            w_fill_count_next = 4'd0;
         end
      endcase
   end

   // State and fill counter registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= StFill;
         r_fill_count <= 4'd0;
      end else begin
         r_state      <= w_state_next;
         r_fill_count <= w_fill_count_next;
      end
   end

   // Lane storage: written only on accepting edges so lanes stay stable while full.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) begin
            r_lane[i] <= 8'd0;
         end
      end else if (w_accept) begin
         r_lane[r_fill_count[2:0]] <= w_q8;
      end
   end

   // Sticky overrun: a beat offered while not ready, including the release cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_overrun <= 1'b0;
      end else if (in_valid && (r_state == StFull)) begin
         r_overrun <= 1'b1;
      end
   end

   assign in_ready   = (r_state == StFill);
   assign out_valid  = (r_state == StFull);
   assign fill_count = r_fill_count;
   assign overrun    = r_overrun;
   assign out_x0     = r_lane[0];
   assign out_x1     = r_lane[1];
   assign out_x2     = r_lane[2];
   assign out_x3     = r_lane[3];
   assign out_x4     = r_lane[4];
   assign out_x5     = r_lane[5];
   assign out_x6     = r_lane[6];
   assign out_x7     = r_lane[7];

endmodule

// File: tb/tb_layer_requant_buffer.sv
// Testbench for layer_requant_buffer: two instances (SHIFT=7 and SHIFT=0) share
// stimulus; a reference model builds expected vectors into scoreboard queues that
// a negedge monitor pops on each output handshake.
module tb_layer_requant_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_data;
   logic        in_valid;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, overrun_a;
   logic [3:0]  fc_a;
   logic [7:0]  xa [8];
   logic        in_ready_b, out_valid_b, overrun_b;
   logic [3:0]  fc_b;
   logic [7:0]  xb [8];

   int errors = 0;
   int checks = 0;

   // Reference model state.
   int          m_cnt = 0;
   bit          m_full = 1'b0;
   bit          m_ovr = 1'b0;
   int          m_l7 [8] = '{default: 0};
   int          m_l0 [8] = '{default: 0};
   logic [63:0] q7 [$];
   logic [63:0] q0 [$];
   bit          started = 1'b0;

   always #5 clk = ~clk;

   layer_requant_buffer #(.SHIFT(7)) u_dut_a (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_a),
      .out_x0(xa[0]), .out_x1(xa[1]), .out_x2(xa[2]), .out_x3(xa[3]),
      .out_x4(xa[4]), .out_x5(xa[5]), .out_x6(xa[6]), .out_x7(xa[7]),
      .out_valid(out_valid_a), .out_ready(out_ready), .fill_count(fc_a),
      .overrun(overrun_a)
   );

   layer_requant_buffer #(.SHIFT(0)) u_dut_b (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_b),
      .out_x0(xb[0]), .out_x1(xb[1]), .out_x2(xb[2]), .out_x3(xb[3]),
      .out_x4(xb[4]), .out_x5(xb[5]), .out_x6(xb[6]), .out_x7(xb[7]),
      .out_valid(out_valid_b), .out_ready(out_ready), .fill_count(fc_b),
      .overrun(overrun_b)
   );

   // Requantization straight from the arithmetic definition.
   function automatic int requant(input int v, input int sh);
      int r;
      int rt;
`ifdef LRB_ROUND_EN
      rt = (sh > 0) ? (1 << (sh - 1)) : 0;
`else
      rt = 0;
`endif
      r = (v + rt) >>> sh;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   function automatic logic [63:0] pack_m(input int l [8]);
      logic [63:0] p;
      for (int i = 0; i < 8; i++) p[8*i +: 8] = 8'(l[i]);
      return p;
   endfunction

   function automatic logic [63:0] pack_d(input logic [7:0] x [8]);
      logic [63:0] p;
      for (int i = 0; i < 8; i++) p[8*i +: 8] = x[i];
      return p;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, then advance the model on the same edge.
   task automatic cycle(input logic v, input logic [15:0] d, input logic ordy,
                        input logic rst);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      reset     = rst;
      @(posedge clk);
      if (!rst) begin
         if (m_full) begin
            void'(q7.pop_back());
            void'(q0.pop_back());
         end
         m_cnt  = 0;
         m_full = 1'b0;
         m_ovr  = 1'b0;
         for (int i = 0; i < 8; i++) begin
            m_l7[i] = 0;
            m_l0[i] = 0;
         end
      end else if (!m_full) begin
         if (v) begin
            m_l7[m_cnt] = requant(int'($signed(d)), 7);
            m_l0[m_cnt] = requant(int'($signed(d)), 0);
            m_cnt++;
            if (m_cnt == 8) begin
               m_full = 1'b1;
               q7.push_back(pack_m(m_l7));
               q0.push_back(pack_m(m_l0));
            end
         end
      end else begin
         if (v) m_ovr = 1'b1;
         if (ordy) begin
            m_full = 1'b0;
            m_cnt  = 0;
         end
      end
      #1;
   endtask

   task automatic fill8_random();
      for (int i = 0; i < 8; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b1);
   endtask

   // Monitor: status and lanes every cycle, scoreboard pop on each handshake.
   always @(negedge clk) begin
      if (started) begin
         chk("status_a", 64'({fc_a, in_ready_a, out_valid_a, overrun_a}),
             64'({4'(m_cnt), !m_full, m_full, m_ovr}));
         chk("status_b", 64'({fc_b, in_ready_b, out_valid_b, overrun_b}),
             64'({4'(m_cnt), !m_full, m_full, m_ovr}));
         chk("lanes_a", pack_d(xa), pack_m(m_l7));
         chk("lanes_b", pack_d(xb), pack_m(m_l0));
         if (reset && out_valid_a && out_ready) begin
            if (q7.size() == 0 || q0.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL vector: got unexpected out_valid required none at %0t", $time);
            end else begin
               chk("vector_a", pack_d(xa), q7.pop_front());
               chk("vector_b", pack_d(xb), q0.pop_front());
            end
         end
      end
   end

   initial begin
      int          dir [8];
      int          beats [8];
      logic [63:0] snap;
      logic [63:0] tmp;

      reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      cycle(1'b0, 16'd0, 1'b0, 1'b0);
      cycle(1'b0, 16'd0, 1'b0, 1'b0);
      started = 1'b1;
      chk("reset_state", 64'({fc_a, in_ready_a, out_valid_a, overrun_a}), 64'(7'b0000100));

      // Directed fill: out_valid appears after the 8th accept.
      beats = '{256, 512, -256, 0, 128, -128, 384, 640};
      for (int i = 0; i < 8; i++) begin
         chk("dir_not_valid", 64'(out_valid_a), 64'(0));
         cycle(1'b1, 16'(beats[i]), 1'b0, 1'b1);
      end
      chk("dir_valid", 64'(out_valid_a), 64'(1));
      chk("dir_fill8", 64'(fc_a), 64'(8));
      dir = '{2, 4, -2, 0, 1, -1, 3, 5};
      chk("dir_lanes", pack_d(xa), pack_m(dir));
      cycle(1'b0, 16'd0, 1'b1, 1'b1);

      // Rounding and saturation.
      beats = '{192, -192, 32767, -32768, 0, 0, 0, 0};
      for (int i = 0; i < 8; i++) cycle(1'b1, 16'(beats[i]), 1'b0, 1'b1);
      tmp = pack_d(xa);
`ifdef LRB_ROUND_EN
      chk("round_sat_a", 64'(tmp[31:0]), 64'(32'h807FFF02));
`else
      chk("round_sat_a", 64'(tmp[31:0]), 64'(32'h807FFE01));
`endif
      tmp = pack_d(xb);
      chk("sat_shift0_b", 64'(tmp[31:0]), 64'(32'h807F807F));
      cycle(1'b0, 16'd0, 1'b1, 1'b1);

      // Backpressure with overrun beats.
      fill8_random();
      snap = pack_m(m_l7);
      for (int i = 0; i < 5; i++) cycle(i < 2, 16'($urandom), 1'b0, 1'b1);
      chk("bp_lanes", pack_d(xa), snap);
      chk("bp_overrun", 64'(overrun_a), 64'(1));
      chk("bp_fill", 64'(fc_a), 64'(8));
      cycle(1'b0, 16'd0, 1'b1, 1'b1);
      chk("bp_release", 64'({out_valid_a, in_ready_a, fc_a}), 64'({1'b0, 1'b1, 4'd0}));

      // Reset mid-fill, then a fresh fill.
      for (int i = 0; i < 5; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b1);
      cycle(1'b1, 16'h1234, 1'b0, 1'b0);
      chk("mid_reset_fill", 64'(fc_a), 64'(0));
      chk("mid_reset_lanes", pack_d(xa), 64'(0));
      chk("mid_reset_ovr", 64'(overrun_a), 64'(0));
      fill8_random();
      chk("refill_valid", 64'(out_valid_a), 64'(1));
      cycle(1'b0, 16'd0, 1'b1, 1'b1);

      // Beat on the release cycle is dropped.
      fill8_random();
      cycle(1'b1, 16'h7FFF, 1'b1, 1'b1);
      chk("rel_beat_ovr", 64'(overrun_a), 64'(1));
      chk("rel_beat_fill", 64'(fc_a), 64'(0));
      cycle(1'b1, 16'(640), 1'b0, 1'b1);
      tmp = pack_d(xa);
      chk("rel_next_lane0", 64'(tmp[7:0]), 64'(8'd5));
      for (int i = 0; i < 7; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b1);
      cycle(1'b0, 16'd0, 1'b1, 1'b1);

      // Random traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         logic [15:0] d;
         d = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 1023)) - 512);
         cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) == 0,
               $urandom_range(0, 99) != 0);
      end

      cycle(1'b0, 16'd0, 1'b1, 1'b1);
      cycle(1'b0, 16'd0, 1'b1, 1'b1);
      chk("queue_empty", 64'(q7.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/layer_requant_buffer.md
# layer_requant_buffer

Collects the 16-bit saturated results of one hidden layer (eight `neuron8` output beats), requantizes each to signed 8-bit, and presents them as a parallel 8-lane feature vector to the next layer's `neuron8` x0..x7 inputs. It sits directly downstream of `neuron8` (or a neuron sequencer driving it) and upstream of the next layer, decoupling the serial result stream from parallel consumption with a valid/ready output handshake.

## Interface
- `SHIFT`, default 7: arithmetic right-shift applied during requantization; legal range 0..15.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-low reset (asserted when 0, sampled on `clk` rising edge).
- `in_data`  input  16  signed neuron result; connects to `neuron8.out`.
- `in_valid`  input  1  result beat valid; connects to `neuron8.valid_out`.
- `in_ready`  output  1  buffer can accept a beat this cycle.
- `out_x0`..`out_x7`  output  8 each  signed requantized lanes; lane n = nth accepted beat.
- `out_valid`  output  1  vector complete and stable.
- `out_ready`  input  1  consumer takes the vector when high with `out_valid`.
- `fill_count`  output  4  beats stored, 0..8.
- `overrun`  output  1  sticky: a beat arrived while `in_ready` was low.

## Operation
- Two states: FILL (reset state) and FULL.
- FILL: `in_ready`=1. On an edge with `in_valid`=1, the requantized `in_data` is written to lane `fill_count`, and `fill_count` increments. The 8th accept (`fill_count` 7->8) moves the state to FULL on the same edge.
- FULL: `in_ready`=0, `out_valid`=1, and lanes are held stable. On an edge with `out_ready`=1, the block clears `fill_count` to 0 and returns to FILL. Lane registers keep their old values; only `out_valid` deasserts.
- There is no bypass: a beat presented in the same cycle as the releasing `out_ready` is dropped and counts as an overrun.
- Overrun: `in_valid`=1 while `in_ready`=0 sets `overrun`=1. The beat is discarded and no lane is modified. `overrun` clears only on reset.
- Requantization, computed in 18-bit signed arithmetic:
  - r = in_data + round_term.
  - q = r >>> SHIFT (arithmetic shift).
  - Saturate q to [-128, 127].
  - round_term is defined under Configuration. With `SHIFT`=0, round_term=0 and the result is a saturate-only mapping.
- Reset (reset=0 on an edge, any state, including mid-fill or while FULL):
  - State returns to FILL.
  - `fill_count`=0, all lanes=0, `out_valid`=0, `overrun`=0, `in_ready`=1 on the following cycle.
  - A beat coincident with the reset edge is discarded.

## Timing
- All outputs are registered or decoded purely from registered state; there is no combinational input-to-output path.
- `in_ready` = (state==FILL). `out_valid` = (state==FULL).
- Latency: `out_valid` rises in the cycle after the edge that accepts the 8th beat. Back-to-back beats give a fill of 8 cycles, then `out_valid` on cycle 9.
- Minimum vector period is 9 cycles: 8 accepts plus 1 release cycle.
- `out_x*` change only on accepting edges in FILL, so they are stable for the whole time `out_valid` is high.

## Configuration
- Macro `LRB_ROUND_EN`:
  - Defined: round_term = 1 << (SHIFT-1) for SHIFT>0, giving round-half-up.
  - Undefined: round_term = 0, giving floor (truncation toward -inf).
- Only the requantization adder differs; the FSM and handshake are identical in both builds.

## Test plan
- Reset, then 8 back-to-back beats 256,512,-256,0,128,-128,384,640 with SHIFT=7 -> `out_valid` on cycle 9, lanes 2,4,-2,0,1,-1,3,5, `fill_count`=8.
- Rounding, one beat each of 192 and -192 (SHIFT=7):
  - With `LRB_ROUND_EN`: lanes 2 and -1.
  - Without it: lanes 1 and -2.
- Saturation: beats 32767 and -32768 (SHIFT=7) -> 127 and -128 in both builds; beat 32767 with SHIFT=0 -> 127.
- Backpressure:
  - Fill 8 beats, hold `out_ready`=0 for 5 cycles and drive 2 extra beats -> lanes unchanged, `overrun`=1, `fill_count` stays 8.
  - Then raise `out_ready` for 1 cycle -> `out_valid`=0 and `in_ready`=1 on the next cycle, `fill_count`=0.
- Reset mid-fill: accept 5 beats, assert reset=0 for 1 edge -> `fill_count`=0, lanes 0, `overrun`=0. A fresh 8-beat fill then completes normally.
- Release-cycle beat: drive `in_valid`=1 in the same cycle `out_ready` releases FULL -> beat dropped, `overrun`=1, the next vector starts at lane 0 with the following beat.
